// File: rtl/inst_loader_if.sv
// Byte-stream and instruction-memory write bundle for inst_loader.
// master = stream source / observer side, slave = loader side.
interface inst_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, busy, done, err
    );
endinterface

// File: rtl/inst_loader.sv
// Framed byte-stream loader for the instruction memory.
// Assembles MSB-first 32-bit words, writes them from address 0, checks XOR.
module inst_loader #(
    parameter int ADDR_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    inst_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CKSUM,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_nwords;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_word;
    logic [7:0]        r_xor;

    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_last;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_last   = (r_widx == r_nwords);

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; byte-consuming states advance only on a handshake.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_HDR;
            S_HDR:   if (w_accept) w_next = S_DATA;
            S_DATA:  if (w_accept && r_bcnt == 2'd3) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_CKSUM : S_DATA;
            S_CKSUM: if (w_accept) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: counters, word assembly, running XOR and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nwords    <= '0;
            r_widx      <= '0;
            r_bcnt      <= '0;
            r_word      <= '0;
            r_xor       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err  <= 1'b0;
                        r_widx <= '0;
                        r_bcnt <= '0;
                        r_xor  <= '0;
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_nwords <= bus.in_data[ADDR_W-1:0];
                        r_xor    <= r_xor ^ bus.in_data;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= {r_word[23:0], bus.in_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        r_xor  <= r_xor ^ bus.in_data;
                        if (r_bcnt == 2'd3) begin
                            r_mem_addr  <= r_widx;
                            r_mem_wdata <= {r_word[23:0], bus.in_data};
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_last) r_widx <= r_widx + 1'b1;
                end
                S_CKSUM: begin
                    if (w_accept && bus.in_data != r_xor) r_err <= 1'b1;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_next == S_HDR) || (w_next == S_DATA) ||
                          (w_next == S_CKSUM);
            r_mem_we   <= (w_next == S_WRITE);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_busy;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
